// File: rtl/rf_pkg.sv
// Shared register-file types and widths, also used by the WB stage.
package rf_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// In-order FIFO holding long-latency results {reg, data} until they win the write port.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [REG_W-1:0]              push_reg,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [REG_W-1:0]              head_reg,
    output logic [DATA_W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    logic [REG_W-1:0]  mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == COUNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_reg  = mem_reg[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr]  <= push_reg;
            mem_data[wr_ptr] <= push_data;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between WB and the long-latency return path,
// with a starvation guard and a busy scoreboard for decode hazard stalls.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_hold,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [REG_W-1:0]  ll_reg,
    input  logic [DATA_W-1:0] ll_data,
    input  logic              ll_issue,
    input  logic [REG_W-1:0]  ll_issue_reg,
    input  logic [REG_W-1:0]  dec_rs,
    input  logic [REG_W-1:0]  dec_rt,
    input  logic [REG_W-1:0]  dec_rd,
    output logic              stall,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic [REG_W-1:0]   head_reg;
    logic [DATA_W-1:0]  head_data;
    logic [COUNT_W-1:0] fifo_count;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               wb_wins;
    logic [3:0]         age;
    logic [31:0]        busy;
    logic [31:0]        busy_next;
    rf_wr_t             wr;

    // A popping register is forwarded by the file, so it does not stall.
    function automatic logic hit(input logic [REG_W-1:0] r, input logic [31:0] b,
                                 input logic p, input logic [REG_W-1:0] hr);
        return (r != REG_ZERO) && b[r] && !(p && (hr == r));
    endfunction

    assign ll_ready = (fifo_count < COUNT_W'(DEPTH));
    assign push     = ll_valid && ll_ready && (ll_reg != REG_ZERO);
    assign wb_hold  = (age >= 4'(STARVE_LIMIT));
    assign wb_wins  = !wb_hold && wb_valid && (wb_reg != REG_ZERO);
    assign pop      = !fifo_empty && !wb_wins;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_reg  (ll_reg),
        .push_data (ll_data),
        .pop       (pop),
        .head_reg  (head_reg),
        .head_data (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        wr = '0;
        if (pop) begin
            wr.we   = 1'b1;
            wr.addr = head_reg;
            wr.data = head_data;
        end else if (wb_wins) begin
            wr.we   = 1'b1;
            wr.addr = wb_reg;
            wr.data = wb_data;
        end
    end

    assign rf_we    = wr.we;
    assign rf_waddr = wr.addr;
    assign rf_wdata = wr.data;

    // Set is applied after clear so a coincident re-issue keeps the bit.
    always_comb begin
        busy_next = busy;
        if (pop)      busy_next[head_reg]     = 1'b0;
        if (ll_issue) busy_next[ll_issue_reg] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        stall = hit(dec_rs, busy, pop, head_reg) |
                hit(dec_rt, busy, pop, head_reg) |
                hit(dec_rd, busy, pop, head_reg) |
                (ll_issue && busy[ll_issue_reg]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age  <= '0;
            busy <= '0;
        end else begin
            busy <= busy_next;
            if (pop)
                age <= '0;
            else if (!fifo_empty && (age != 4'hF))
                age <= age + 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a scoreboard of expected register-file writes.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic              clk;
    logic              reset;
    logic              wb_valid;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              wb_hold;
    logic              ll_valid;
    logic              ll_ready;
    logic [4:0]        ll_reg;
    logic [31:0]       ll_data;
    logic              ll_issue;
    logic [4:0]        ll_issue_reg;
    logic [4:0]        dec_rs;
    logic [4:0]        dec_rt;
    logic [4:0]        dec_rd;
    logic              stall;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    int     check_count = 0;
    int     pass_count  = 0;
    rf_wr_t exp_q[$];

    rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_hold      (wb_hold),
        .ll_valid     (ll_valid),
        .ll_ready     (ll_ready),
        .ll_reg       (ll_reg),
        .ll_data      (ll_data),
        .ll_issue     (ll_issue),
        .ll_issue_reg (ll_issue_reg),
        .dec_rs       (dec_rs),
        .dec_rt       (dec_rt),
        .dec_rd       (dec_rd),
        .stall        (stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            pass_count++;
    endtask

    task automatic applyStimulus(input logic wbv, input logic [4:0] wbr, input logic [31:0] wbd,
                                 input logic llv, input logic [4:0] llr, input logic [31:0] lld);
        wb_valid = wbv;
        wb_reg   = wbr;
        wb_data  = wbd;
        ll_valid = llv;
        ll_reg   = llr;
        ll_data  = lld;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        rf_wr_t e;
        e.we   = 1'b1;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_ll_ready"}, 32'(ll_ready), 32'd1);
        checkOutput({tag, "_stall"},    32'(stall),    32'd0);
        checkOutput({tag, "_wb_hold"},  32'(wb_hold),  32'd0);
        checkOutput({tag, "_rf_we"},    32'(rf_we),    32'd0);
        checkOutput({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
        checkOutput({tag, "_rf_wdata"}, rf_wdata,      32'd0);
    endtask

    // Every write the DUT makes must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_we", 32'(rf_we), 32'd0);
            end else begin
                rf_wr_t e;
                e = exp_q.pop_front();
                checkOutput("sb_wr_addr", 32'(rf_waddr), 32'(e.addr));
                checkOutput("sb_wr_data", rf_wdata, e.data);
            end
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        ll_issue = 1'b0; ll_issue_reg = 5'd0;
        dec_rs = 5'd0; dec_rt = 5'd0; dec_rd = 5'd0;
        repeat (2) @(posedge clk);
        sample();
        check_reset_outputs("por");
        next_cycle();
        reset = 1'b1;

        // Priority: WB beats a waiting LL head, head follows when WB idles.
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAA);
        sample();
        checkOutput("prio_empty_we", 32'(rf_we), 32'd0);
        next_cycle();
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd3, 32'h11);
        sample();
        checkOutput("prio_wb_addr", 32'(rf_waddr), 32'd3);
        checkOutput("prio_wb_data", rf_wdata, 32'h11);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd5, 32'hAA);
        sample();
        checkOutput("prio_ll_addr", 32'(rf_waddr), 32'd5);
        checkOutput("prio_ll_data", rf_wdata, 32'hAA);

        // Scoreboard set, forward on pop, clear.
        next_cycle();
        ll_issue = 1'b1; ll_issue_reg = 5'd8;
        next_cycle();
        ll_issue = 1'b0; dec_rs = 5'd8;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
        sample();
        checkOutput("sb_rs_hit", 32'(stall), 32'd1);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd8, 32'h88);
        sample();
        checkOutput("sb_pop_fwd", 32'(stall), 32'd0);
        checkOutput("sb_pop_addr", 32'(rf_waddr), 32'd8);
        next_cycle();
        dec_rs = 5'd0; dec_rt = 5'd8;
        sample();
        checkOutput("sb_cleared", 32'(stall), 32'd0);

        // Re-issue in the pop cycle keeps the bit set.
        next_cycle();
        dec_rt = 5'd0; ll_issue = 1'b1; ll_issue_reg = 5'd8;
        next_cycle();
        ll_issue = 1'b0; dec_rd = 5'd8;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h81);
        sample();
        checkOutput("sb_rd_hit", 32'(stall), 32'd1);
        next_cycle();
        dec_rd = 5'd0; ll_issue = 1'b1; ll_issue_reg = 5'd8;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd8, 32'h81);
        sample();
        checkOutput("sb_reissue_addr", 32'(rf_waddr), 32'd8);
        checkOutput("sb_issue_waw", 32'(stall), 32'd1);
        next_cycle();
        ll_issue = 1'b0; dec_rs = 5'd8;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h82);
        sample();
        checkOutput("sb_set_wins", 32'(stall), 32'd1);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd8, 32'h82);
        sample();
        checkOutput("sb_final_pop", 32'(stall), 32'd0);
        next_cycle();
        dec_rs = 5'd0;

        // Starvation: continuous WB, LL head forced through on the 5th cycle.
        next_cycle();
        applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99);
        expect_wr(5'd1, 32'h100);
        sample();
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            applyStimulus(1'b1, 5'd1, 32'(32'h100 + i), 1'b0, 5'd0, 32'd0);
            expect_wr(5'd1, 32'(32'h100 + i));
            sample();
            checkOutput($sformatf("starve_nohold_%0d", i), 32'(wb_hold), 32'd0);
        end
        next_cycle();
        applyStimulus(1'b1, 5'd1, 32'h105, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd9, 32'h99);
        sample();
        checkOutput("starve_hold", 32'(wb_hold), 32'd1);
        checkOutput("starve_addr", 32'(rf_waddr), 32'd9);
        next_cycle();
        expect_wr(5'd1, 32'h105);
        sample();
        checkOutput("starve_age_clr", 32'(wb_hold), 32'd0);
        checkOutput("starve_wb_retry", 32'(rf_waddr), 32'd1);

        // Full FIFO refuses a third entry, even in a pop cycle.
        next_cycle();
        applyStimulus(1'b1, 5'd2, 32'h200, 1'b1, 5'd10, 32'hA0);
        expect_wr(5'd2, 32'h200);
        next_cycle();
        applyStimulus(1'b1, 5'd2, 32'h201, 1'b1, 5'd11, 32'hB0);
        expect_wr(5'd2, 32'h201);
        sample();
        checkOutput("full_ready_1", 32'(ll_ready), 32'd1);
        next_cycle();
        applyStimulus(1'b1, 5'd2, 32'h202, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd2, 32'h202);
        sample();
        checkOutput("full_ready_0", 32'(ll_ready), 32'd0);
        next_cycle();
        applyStimulus(1'b1, 5'd2, 32'h203, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd2, 32'h203);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd10, 32'hA0);
        sample();
        checkOutput("full_pop_ready", 32'(ll_ready), 32'd0);
        checkOutput("full_pop_addr", 32'(rf_waddr), 32'd10);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd11, 32'hB0);
        sample();
        checkOutput("full_second_addr", 32'(rf_waddr), 32'd11);
        next_cycle();
        sample();
        checkOutput("full_third_dropped", 32'(rf_we), 32'd0);

        // LL results to r0 vanish; WB to r0 does not block a pop.
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        next_cycle();
        sample();
        checkOutput("r0_ready", 32'(ll_ready), 32'd1);
        checkOutput("r0_no_we", 32'(rf_we), 32'd0);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD0);
        sample();
        checkOutput("r0_never_written", 32'(rf_we), 32'd0);
        next_cycle();
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd13, 32'hD0);
        sample();
        checkOutput("wb_r0_no_block", 32'(rf_waddr), 32'd13);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset mid-stream with two entries queued and r8 busy.
        next_cycle();
        applyStimulus(1'b1, 5'd2, 32'h300, 1'b1, 5'd20, 32'hE0);
        ll_issue = 1'b1; ll_issue_reg = 5'd8;
        expect_wr(5'd2, 32'h300);
        next_cycle();
        applyStimulus(1'b1, 5'd2, 32'h301, 1'b1, 5'd21, 32'hE1);
        ll_issue = 1'b0;
        expect_wr(5'd2, 32'h301);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        dec_rs = 5'd8;
        #1;
        checkOutput("pre_rst_stall", 32'(stall), 32'd1);
        checkOutput("pre_rst_ready", 32'(ll_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        next_cycle();
        reset = 1'b1;
        sample();
        checkOutput("post_rst_ready", 32'(ll_ready), 32'd1);
        checkOutput("post_rst_stall", 32'(stall), 32'd0);
        checkOutput("post_rst_we", 32'(rf_we), 32'd0);
        next_cycle();
        dec_rs = 5'd0;
        sample();

        checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
